// File: rtl/data_memory_responder_if.sv
// Request/response bus between the memory stage (master) and the data memory (slave).
interface data_memory_responder_if;
  logic        req;
  logic        ready;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic        resp_valid;
  logic [63:0] Read_Data;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output req, Mem_Addr, Write_Data, MemRead, MemWrite,
    input  ready, resp_valid, Read_Data, err, err_code
  );

  modport slave (
    input  req, Mem_Addr, Write_Data, MemRead, MemWrite,
    output ready, resp_valid, Read_Data, err, err_code
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle doubleword load/store data memory with fixed wait states and error reporting.
// Only aligned accesses commit, so storage is kept as 64-bit little-endian words.
module data_memory_responder #(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave bus
);
  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int WIDX = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [63:0] addr_reg, wdata_reg;
  logic rd_reg, wr_reg;
  logic [63:0] rdata_reg;
  logic err_reg;
  logic [1:0] code_reg;
  logic [63:0] mem [WORDS];

  logic accept;
  logic enter_resp;
  logic [63:0] eff_addr, eff_wdata;
  logic eff_rd, eff_wr;
  logic [1:0] code_next;
  logic [WIDX-1:0] eff_idx;

  assign accept = bus.req && (state_reg == S_IDLE) && (bus.MemRead || bus.MemWrite);

  // With zero wait states the commit happens on the accept edge, so use the live inputs.
  always_comb begin
    eff_addr  = addr_reg;
    eff_wdata = wdata_reg;
    eff_rd    = rd_reg;
    eff_wr    = wr_reg;
    if (state_reg == S_IDLE) begin
      eff_addr  = bus.Mem_Addr;
      eff_wdata = bus.Write_Data;
      eff_rd    = bus.MemRead;
      eff_wr    = bus.MemWrite;
    end
  end

  always_comb begin
    code_next = 2'b00;
    if (eff_rd && eff_wr)
      code_next = 2'b11;
    else if (eff_addr[2:0] != 3'd0)
      code_next = 2'b01;
    else if (eff_addr > MAX_ADDR)
      code_next = 2'b10;
  end

  assign eff_idx = eff_addr[3 +: WIDX];
  assign enter_resp = (state_next == S_RESP) && (state_reg != S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0)
          state_next = S_RESP;
        else
          cnt_next = cnt_reg - 4'd1;
      end
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready      = (state_reg == S_IDLE);
    bus.resp_valid = (state_reg == S_RESP);
    bus.Read_Data  = rdata_reg;
    bus.err        = err_reg;
    bus.err_code   = code_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      code_reg  <= 2'b00;
    end else begin
      if (accept) begin
        addr_reg  <= bus.Mem_Addr;
        wdata_reg <= bus.Write_Data;
        rd_reg    <= bus.MemRead;
        wr_reg    <= bus.MemWrite;
      end
      if (enter_resp) begin
        err_reg   <= (code_next != 2'b00);
        code_reg  <= code_next;
        rdata_reg <= (code_next == 2'b00 && eff_rd) ? mem[eff_idx] : 64'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++)
        mem[i] <= '0;
    end else if (enter_resp && code_next == 2'b00 && eff_wr) begin
      mem[eff_idx] <= eff_wdata;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: a 2-wait-state instance driven from a vector table, plus a zero-wait instance.
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  data_memory_responder #(.DEPTH_BYTES(64), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  data_memory_responder #(.DEPTH_BYTES(64), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int sel = 0;
  logic req_s = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
  logic [63:0] addr_s = '0, wdata_s = '0;

  assign bus0.req = (sel == 0) ? req_s : 1'b0;
  assign bus1.req = (sel == 1) ? req_s : 1'b0;
  assign bus0.MemRead = rd_s;
  assign bus1.MemRead = rd_s;
  assign bus0.MemWrite = wr_s;
  assign bus1.MemWrite = wr_s;
  assign bus0.Mem_Addr = addr_s;
  assign bus1.Mem_Addr = addr_s;
  assign bus0.Write_Data = wdata_s;
  assign bus1.Write_Data = wdata_s;

  logic o_ready, o_rv, o_err;
  logic [63:0] o_rd;
  logic [1:0] o_code;
  assign o_ready = (sel == 1) ? bus1.ready : bus0.ready;
  assign o_rv    = (sel == 1) ? bus1.resp_valid : bus0.resp_valid;
  assign o_rd    = (sel == 1) ? bus1.Read_Data : bus0.Read_Data;
  assign o_err   = (sel == 1) ? bus1.err : bus0.err;
  assign o_code  = (sel == 1) ? bus1.err_code : bus0.err_code;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic [1:0]  exp_code;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge (cycle 0) and returns at the negedge of cycle W+2.
  task automatic run_txn(input int which, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic [1:0] exp_code);
    int w;
    int resp_at;
    int nresp;
    logic low_ok;
    logic [63:0] got_d;
    logic got_e;
    logic [1:0] got_c;
    w = (which == 0) ? 2 : 0;
    sel = which;
    req_s = 1'b1; rd_s = rd; wr_s = wr; addr_s = addr; wdata_s = wdata;
    #1;
    chk("ready_cycle0", 64'(o_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_s = 1'b0; rd_s = ~rd; wr_s = ~wr; addr_s = ~addr; wdata_s = ~wdata;
    resp_at = -1; nresp = 0; low_ok = 1'b1;
    got_d = '0; got_e = 1'b0; got_c = 2'b00;
    for (int k = 1; k <= w + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (o_rv) begin
        nresp++;
        if (resp_at < 0) resp_at = k;
        got_d = o_rd; got_e = o_err; got_c = o_code;
      end
      if (o_ready) low_ok = 1'b0;
    end
    @(negedge clk);
    chk("resp_cycle", 64'(resp_at), 64'(w + 1));
    chk("resp_count", 64'(nresp), 64'd1);
    chk("ready_low", 64'(low_ok), 64'd1);
    chk("read_data", got_d, exp_data);
    chk("err", 64'(got_e), 64'(exp_code != 2'b00));
    chk("err_code", 64'(got_c), 64'(exp_code));
    chk("ready_back", 64'(o_ready), 64'd1);
    chk("rv_drop", 64'(o_rv), 64'd0);
    chk("data_hold", o_rd, exp_data);
    $display("txn dut%0d rd=%0b wr=%0b addr=%h wdata=%h -> resp@%0d data=%h err=%0b code=%b",
             which, rd, wr, addr, wdata, resp_at, got_d, got_e, got_c);
    rd_s = 1'b0; wr_s = 1'b0;
  endtask

  vec_t vecs[14];
  int rv_seen;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h10, 64'h1122334455667788, 64'h0, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 64'h13, 64'h0, 64'h0, 2'b01};
    vecs[3]  = '{1'b1, 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 64'h38, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 64'h40, 64'hDEAD_BEEF_0000_0001, 64'h0, 2'b10};
    vecs[6]  = '{1'b1, 1'b0, 64'h38, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 64'h40, 64'h0, 64'h0, 2'b10};
    vecs[8]  = '{1'b1, 1'b1, 64'h3, 64'h1234, 64'h0, 2'b11};
    vecs[9]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 2'b10};
    vecs[10] = '{1'b1, 1'b0, 64'h8, 64'h0, 64'h0, 2'b00};
    vecs[11] = '{1'b0, 1'b1, 64'h0, 64'h0102030405060708, 64'h0, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 64'h0, 64'h0, 64'h0102030405060708, 2'b00};
    vecs[13] = '{1'b0, 1'b1, 64'h1_0000_0010, 64'h77, 64'h0, 2'b10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sel = 0; #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_rv", 64'(o_rv), 64'd0);
    chk("rst_data", o_rd, 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_code", 64'(o_code), 64'd0);
    sel = 1; #1;
    chk("rst_ready1", 64'(o_ready), 64'd1);
    chk("rst_rv1", 64'(o_rv), 64'd0);
    sel = 0;

    for (int i = 0; i < 14; i++)
      run_txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_data, vecs[i].exp_code);

    // Neither op set: request must be ignored.
    sel = 0; req_s = 1'b1; rd_s = 1'b0; wr_s = 1'b0; addr_s = 64'h10;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("noop_ready", 64'(o_ready), 64'd1);
      chk("noop_rv", 64'(o_rv), 64'd0);
    end
    req_s = 1'b0;
    $display("txn dut0 noop request held 3 cycles -> ready=%0b rv=%0b", o_ready, o_rv);

    // Reset in cycle 1 of a store abandons it.
    sel = 0; req_s = 1'b1; wr_s = 1'b1; rd_s = 1'b0; addr_s = 64'h8; wdata_s = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req_s = 1'b0; wr_s = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) reset = 1'b0;
      @(negedge clk);
      if (o_rv) rv_seen++;
    end
    chk("midrst_rv", 64'(rv_seen), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    chk("midrst_data", o_rd, 64'd0);
    $display("txn dut0 sd addr=8 aborted by reset -> resp strobes=%0d", rv_seen);
    run_txn(0, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0, 2'b00);
    run_txn(0, 1'b1, 1'b0, 64'h10, 64'h0, 64'h0, 2'b00);

    // Zero wait states: back-to-back store/load.
    run_txn(1, 1'b0, 1'b1, 64'h0, 64'hCAFE_F00D_1357_9BDF, 64'h0, 2'b00);
    run_txn(1, 1'b1, 1'b0, 64'h0, 64'h0, 64'hCAFE_F00D_1357_9BDF, 2'b00);
    run_txn(1, 1'b0, 1'b1, 64'h40, 64'h55, 64'h0, 2'b10);
    run_txn(1, 1'b1, 1'b0, 64'h0, 64'h0, 64'hCAFE_F00D_1357_9BDF, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
